// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the BCD stopwatch.
// The FSM state type, the largest BCD digit value and the default parameter values.
package stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StMaxed = 2'd3
  } state_e;

  localparam logic [3:0]  BcdMax      = 4'd9;
  localparam int unsigned TickDefault = 1_000_000 - 1;
  localparam int unsigned SyncDefault = 2;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Button inputs and display/status outputs of the stopwatch.
// The master modport is the driver of the buttons; the slave modport is the stopwatch itself.
interface stopwatch_bcd_if;

  logic       btn_start;
  logic       btn_clear;
  logic [3:0] displayA;
  logic [3:0] displayB;
  logic [3:0] displayC;
  logic [3:0] displayD;
  logic       running;
  logic       at_max;

  modport master (
    output btn_start, btn_clear,
    input  displayA, displayB, displayC, displayD, running, at_max
  );

  modport slave (
    input  btn_start, btn_clear,
    output displayA, displayB, displayC, displayD, running, at_max
  );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the carry chain: clears, or counts 0..9 on inc.
// The carry is combinational so that all chained digits update on the same edge.
module bcd_digit
  import stopwatch_bcd_pkg::*;
(
  input  logic       clk_10Mhz,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == BcdMax) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == BcdMax);

endmodule

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch (000.0 .. 999.9) controlled by start/stop and clear buttons.
// Buttons are synchronised and edge-detected; a prescaler produces tenth-second ticks in RUN.
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int unsigned TICK_COUNT  = TickDefault,
  parameter int unsigned SYNC_STAGES = SyncDefault
) (
  input  logic           clk_10Mhz,
  input  logic           reset_n,
  stopwatch_bcd_if.slave bus
);

  localparam int unsigned PreW   = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_COUNT);

  logic [SYNC_STAGES-1:0] start_sync_q, clear_sync_q;
  logic                   start_prev_q, clear_prev_q;
  logic                   start_pulse, clear_pulse;

  state_e          state_q, state_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            running_q, at_max_q;
  logic            tick, count_full;

  logic [3:0] dig   [4];
  logic [3:0] carry;
  logic [3:0] inc;
  logic       unused_carry_top;

  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      start_sync_q <= '0;
      clear_sync_q <= '0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      start_sync_q <= (start_sync_q << 1) | SYNC_STAGES'(bus.btn_start);
      clear_sync_q <= (clear_sync_q << 1) | SYNC_STAGES'(bus.btn_clear);
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      clear_prev_q <= clear_sync_q[SYNC_STAGES-1];
    end
  end

  assign start_pulse = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign clear_pulse = clear_sync_q[SYNC_STAGES-1] & ~clear_prev_q;

  assign tick       = (state_q == StRun) && (presc_q == PreMax);
  assign count_full = (dig[3] == BcdMax) && (dig[2] == BcdMax) &&
                      (dig[1] == BcdMax) && (dig[0] == BcdMax);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (state_q == StRun) begin
      presc_d = tick ? '0 : presc_q + PreW'(1);
    end
    if (clear_pulse) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_pulse) state_d = StRun;
        // A tick at 999.9 is dropped and freezes the count; otherwise start may pause.
        StRun: begin
          if (tick && count_full) begin
            state_d = StMaxed;
          end else if (start_pulse) begin
            state_d = StPause;
          end
        end
        StPause: if (start_pulse) state_d = StRun;
        StMaxed: state_d = StMaxed;
        default: state_d = StIdle;
      endcase
    end
    if (clear_pulse || (state_d == StRun && state_q != StRun)) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      running_q <= 1'b0;
      at_max_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= (state_q == StRun);
      at_max_q  <= (state_q == StMaxed);
    end
  end

  // Digit 0 is the tenths (display D); each carry feeds the next digit's inc.
  assign inc[0] = tick & ~count_full;
  assign inc[3:1] = carry[2:0];

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit u_digit (
      .clk_10Mhz (clk_10Mhz),
      .reset_n   (reset_n),
      .clr       (clear_pulse),
      .inc       (inc[i]),
      .digit     (dig[i]),
      .carry     (carry[i])
    );
  end

  // Increments stop at 999.9, so the hundreds digit never carries out.
  assign unused_carry_top = carry[3];

  assign bus.displayA = dig[3];
  assign bus.displayB = dig[2];
  assign bus.displayC = dig[1];
  assign bus.displayD = dig[0];
  assign bus.running  = running_q;
  assign bus.at_max   = at_max_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: two DUTs (TICK_COUNT 9 and 0) against a cycle reference model.
// Directed milestones from the test plan, then randomized button and reset activity.
module tb_stopwatch_bcd;

  localparam int Sync  = 2;
  localparam int MIdle = 0, MRun = 1, MPause = 2, MMax = 3;

  typedef struct {
    int       mode;
    int       count;
    int       k;
    bit       run_o;
    bit       max_o;
    bit [7:0] hs;
    bit [7:0] hc;
  } mdl_t;

  logic clk;
  logic rst_a_n, rst_b_n;
  int   cyc;
  int   n_checks, n_errors;

  stopwatch_bcd_if ifa ();
  stopwatch_bcd_if ifb ();

  stopwatch_bcd #(.TICK_COUNT(9), .SYNC_STAGES(Sync)) u_dut_a (
    .clk_10Mhz (clk),
    .reset_n   (rst_a_n),
    .bus       (ifa)
  );

  stopwatch_bcd #(.TICK_COUNT(0), .SYNC_STAGES(Sync)) u_dut_b (
    .clk_10Mhz (clk),
    .reset_n   (rst_b_n),
    .bus       (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference: one call per rising edge. hs/hc hold the raw button seen at previous edges.
  function automatic mdl_t step(mdl_t m, bit rst_n, bit bs, bit bc, int t);
    mdl_t n;
    bit   sp, cp, tick;
    n = m;
    if (!rst_n) begin
      n.mode = MIdle; n.count = 0; n.k = 0; n.run_o = 0; n.max_o = 0; n.hs = '0; n.hc = '0;
      return n;
    end
    sp = m.hs[Sync-1] & ~m.hs[Sync];
    cp = m.hc[Sync-1] & ~m.hc[Sync];
    n.hs = {m.hs[6:0], bs};
    n.hc = {m.hc[6:0], bc};
    n.run_o = (m.mode == MRun);
    n.max_o = (m.mode == MMax);
    tick = (m.mode == MRun) && (m.k == t);
    if (cp) begin
      n.mode = MIdle; n.count = 0; n.k = 0;
    end else begin
      case (m.mode)
        MIdle:  if (sp) begin n.mode = MRun; n.k = 0; end
        MRun: begin
          n.k = tick ? 0 : m.k + 1;
          if (tick && m.count == 9999) n.mode = MMax;
          else begin
            if (tick) n.count = m.count + 1;
            if (sp) n.mode = MPause;
          end
        end
        MPause: if (sp) begin n.mode = MRun; n.k = 0; end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [17:0] exp_of(mdl_t m);
    return {4'(m.count / 1000), 4'((m.count / 100) % 10), 4'((m.count / 10) % 10),
            4'(m.count % 10), m.run_o, m.max_o};
  endfunction

  logic [17:0] qa[$], qb[$];
  mdl_t        ma, mb;

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    forever begin
      @(posedge clk);
      ma = step(ma, rst_a_n, ifa.btn_start, ifa.btn_clear, 9);
      mb = step(mb, rst_b_n, ifb.btn_start, ifb.btn_clear, 0);
      qa.push_back(exp_of(ma));
      qb.push_back(exp_of(mb));
    end
  end

  // Monitor: the DUT presents a fresh output every cycle; compare it against the queued model value.
  initial begin
    logic [17:0] e, a;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        a = {ifa.displayA, ifa.displayB, ifa.displayC, ifa.displayD, ifa.running, ifa.at_max};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL sb_a cycle %0d: got %h expected %h", cyc, a, e);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        a = {ifb.displayA, ifb.displayB, ifb.displayC, ifb.displayD, ifb.running, ifb.at_max};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL sb_b cycle %0d: got %h expected %h", cyc, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] disp_a();
    return {ifa.displayA, ifa.displayB, ifa.displayC, ifa.displayD};
  endfunction

  function automatic logic [15:0] disp_b();
    return {ifb.displayA, ifb.displayB, ifb.displayC, ifb.displayD};
  endfunction

  task automatic at_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic set_btn(input int d, input bit s, input bit c);
    if (d == 0) begin
      ifa.btn_start = s; ifa.btn_clear = c;
    end else begin
      ifb.btn_start = s; ifb.btn_clear = c;
    end
  endtask

  task automatic press(input int d, input bit s, input bit c);
    set_btn(d, s, c);
    repeat (2) @(negedge clk);
    set_btn(d, 1'b0, 1'b0);
  endtask

  initial begin
    int p, e, p2, q;
    n_checks = 0;
    n_errors = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    set_btn(0, 1'b0, 1'b0);
    set_btn(1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    chk("reset_disp", 32'(disp_a()), 32'h0);
    chk("reset_flags", {30'd0, ifa.running, ifa.at_max}, 32'd0);

    // Start latency, first increment, 25 ticks, carry chain.
    p = cyc;
    ifa.btn_start = 1'b1;
    at_edge(p + 3);
    chk("run_before", 32'(ifa.running), 32'd0);
    at_edge(p + 4);
    chk("run_rise", 32'(ifa.running), 32'd1);
    ifa.btn_start = 1'b0;
    e = p + 3;
    at_edge(e + 9);     chk("first_inc_pre", 32'(disp_a()), 32'h0000);
    at_edge(e + 10);    chk("first_inc", 32'(disp_a()), 32'h0001);
    at_edge(e + 250);   chk("ticks25", 32'(disp_a()), 32'h0025);
    at_edge(e + 990);   chk("c_0099", 32'(disp_a()), 32'h0099);
    at_edge(e + 1000);  chk("c_0100", 32'(disp_a()), 32'h0100);
    at_edge(e + 9990);  chk("c_0999", 32'(disp_a()), 32'h0999);
    at_edge(e + 10000); chk("c_1000", 32'(disp_a()), 32'h1000);
    press(0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("clear1", 32'(disp_a()), 32'h0);

    // Pause after 3 ticks, hold, resume.
    p = cyc;
    press(0, 1'b1, 1'b0);
    e = p + 3;
    at_edge(e + 30);
    chk("three", 32'(disp_a()), 32'h0003);
    p2 = cyc;
    press(0, 1'b1, 1'b0);
    at_edge(p2 + 100);
    chk("paused_disp", 32'(disp_a()), 32'h0003);
    chk("paused_run", 32'(ifa.running), 32'd0);
    q = cyc;
    press(0, 1'b1, 1'b0);
    at_edge(q + 12);    chk("resume_pre", 32'(disp_a()), 32'h0003);
    at_edge(q + 13);    chk("resume_inc", 32'(disp_a()), 32'h0004);
    press(0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);

    // Simultaneous start+clear in IDLE; clear during RUN at 004.7.
    press(0, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    chk("both_run", 32'(ifa.running), 32'd0);
    chk("both_disp", 32'(disp_a()), 32'h0);
    p = cyc;
    press(0, 1'b1, 1'b0);
    e = p + 3;
    at_edge(e + 470);
    chk("at_0047", 32'(disp_a()), 32'h0047);
    press(0, 1'b0, 1'b1);
    at_edge(e + 475);
    chk("clr_run_disp", 32'(disp_a()), 32'h0);
    chk("clr_run_run", 32'(ifa.running), 32'd0);

    // Held start gives one transition; one-cycle reset mid-run.
    p = cyc;
    ifa.btn_start = 1'b1;
    at_edge(p + 50);
    chk("held_run", 32'(ifa.running), 32'd1);
    ifa.btn_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_still", 32'(ifa.running), 32'd1);
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    chk("rst_disp", 32'(disp_a()), 32'h0);
    chk("rst_flags", {30'd0, ifa.running, ifa.at_max}, 32'd0);
    repeat (30) @(negedge clk);
    chk("rst_after", 32'(disp_a()), 32'h0);

    // Saturation at 999.9 on the fast-tick instance.
    press(1, 1'b1, 1'b0);
    for (int i = 0; i < 12000 && !ifb.at_max; i++) @(negedge clk);
    chk("max_flag", 32'(ifb.at_max), 32'd1);
    chk("max_run", 32'(ifb.running), 32'd0);
    chk("max_disp", 32'(disp_b()), 32'h9999);
    press(1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("max_start", 32'(disp_b()), 32'h9999);
    chk("max_hold", 32'(ifb.at_max), 32'd1);
    press(1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("max_clr", 32'(disp_b()), 32'h0);
    chk("max_clr_flag", 32'(ifb.at_max), 32'd0);

    // Random button activity, including bounce and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) ifa.btn_start = ~ifa.btn_start;
      if ($urandom_range(0, 79) == 0) ifa.btn_clear = ~ifa.btn_clear;
      if ($urandom_range(0, 15) == 0) ifb.btn_start = ~ifb.btn_start;
      if ($urandom_range(0, 79) == 0) ifb.btn_clear = ~ifb.btn_clear;
      rst_a_n = ($urandom_range(0, 999) != 0);
      rst_b_n = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Four-digit BCD stopwatch that counts tenths of seconds from 000.0 to 999.9.
- Controlled by two push buttons: start/stop and clear.
- Directly upstream of the four-digit seven-segment driver; its display outputs feed the driver's displayA..displayD inputs (A = leftmost digit, D = rightmost).
- Internally: button synchronisers, rising-edge detection, a tick prescaler, a control FSM and a BCD carry chain.

Parameters:
- TICK_COUNT, 1_000_000-1: prescaler terminal count. At 10 MHz this gives one 0.1 s tick every TICK_COUNT+1 cycles. Simulation uses 9.
- SYNC_STAGES, 2: number of synchroniser flops per button input.

Ports:
- clk_10Mhz  input  1  system clock, 10 MHz.
- reset_n  input  1  reset, synchronous, active-low.
- btn_start  input  1  raw start/stop button, asynchronous, active-high.
- btn_clear  input  1  raw clear button, asynchronous, active-high.
- displayA  output  4  hundreds-of-seconds BCD digit.
- displayB  output  4  tens-of-seconds BCD digit.
- displayC  output  4  seconds BCD digit.
- displayD  output  4  tenths-of-seconds BCD digit.
- running  output  1  high while in RUN.
- at_max  output  1  high while in MAXED (count frozen at 999.9).

Behaviour:
- Reset, sampled on the clk_10Mhz rising edge while reset_n=0:
  - all synchroniser and edge flops cleared to 0;
  - prescaler = 0; state = IDLE;
  - displayA..D = 0; running = 0; at_max = 0.
- Input conditioning:
  - each button passes through SYNC_STAGES flops, then a previous-value flop;
  - a press is a one-cycle pulse on synced=1 and prev=0;
  - latency from raw rising edge to pulse is SYNC_STAGES+1 cycles;
  - held buttons generate no further pulses;
  - no debounce is done here; bounce produces multiple pulses.
- Prescaler:
  - counts only in RUN;
  - at TICK_COUNT it wraps to 0 and asserts tick for one cycle;
  - forced to 0 on every transition into RUN and on clear, so the first increment lands exactly TICK_COUNT+1 cycles after entering RUN.
- FSM states: IDLE, RUN, PAUSE, MAXED.
  - IDLE: count = 0000. start_pulse -> RUN.
  - RUN: tick increments the count. start_pulse -> PAUSE. A tick while count = 9999 is not applied; go to MAXED with the count held at 9999.
  - PAUSE: count held. start_pulse -> RUN.
  - MAXED: count held at 9999; start_pulse ignored.
  - clear_pulse in any state -> IDLE, count = 0000, prescaler = 0.
  - Simultaneous clear_pulse and start_pulse: clear wins; state becomes IDLE, not RUN.
  - Simultaneous tick and start_pulse in RUN: the tick is applied, then the state goes to PAUSE.
- Count arithmetic, on tick:
  - D increments; D = 9 wraps to 0 with carry into C; C carries into B; B into A.
  - All four digits update in the same cycle as the tick; the displayed value changes one cycle after tick.
  - Digits never take values 10–15.
- Output timing:
  - running and at_max are registered from the state.
  - They are high in the cycle following entry to RUN or MAXED respectively.
- Reset mid-count returns everything to reset values on that edge.

Decomposition:
- Shared package (stopwatch_pkg):
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_MAXED (2 bits);
  - BCD_MAX = 4'd9;
  - default TICK value.
- Sub-module bcd_digit:
  - ports: clk_10Mhz, reset_n, clr, inc, digit[3:0], carry;
  - carry is asserted combinationally when inc=1 and digit=9;
  - four instances chained through carry -> inc.

Test Plan (TICK_COUNT=9):
1. Reset, then a start press. Running rises SYNC_STAGES+2 cycles after the raw press. The first increment to 000.1 occurs 10 cycles after entering RUN. After 25 ticks the digits read 0,0,2,5 (A..D).
2. Carry chain: preload by running to 009.9, one more tick -> 010.0. Run from 099.9 -> 100.0. All digits change in the same cycle.
3. Second start press after 3 ticks -> PAUSE, count frozen at 000.3 for 100 cycles. Third press -> RUN, and the next increment comes 10 cycles later.
4. Run to 999.9, then one further tick -> at_max=1, running=0, count stays 9,9,9,9; a start press changes nothing. A clear press -> 0000, state IDLE, at_max=0.
5. Raise start and clear in the same cycle while in IDLE -> remains IDLE at 0000, running=0. Clear while in RUN at 004.7 -> 0000, running=0.
6. Hold btn_start high for 50 cycles -> exactly one transition. Assert reset_n=0 for one cycle mid-run -> all outputs 0 on that edge, no later spurious increment.
